// File: rtl/usb_pkg.sv
// Shared USB controller types and constants.
// Used by the NRZI decoder and its control FSM.
package usb_pkg;

    typedef enum logic [1:0] {
        NRZI_IDLE  = 2'd0,
        NRZI_HUNT  = 2'd1,
        NRZI_DATA  = 2'd2,
        NRZI_ABORT = 2'd3
    } nrzi_dec_state_t;

    localparam logic [7:0]  SYNC_PATTERN_DEFAULT = 8'b0000_0001;
    localparam int unsigned MAX_ONES_RUN         = 6;

    // No line transition decodes to 1, a transition decodes to 0.
    function automatic logic nrzi_bit(input logic line, input logic prev);
        return ~(line ^ prev);
    endfunction

endpackage

// File: rtl/nrzi_decode_fsm.sv
// Control FSM for the NRZI receive decoder: state register and event pulses.
// NRZI_STUFF_ERR_EN adds the bit-stuff violation exit from DATA.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// NRZI_IDLE  | no packet; first bit with rx_active starts the SYNC hunt
// NRZI_HUNT  | shifting decoded bits in, looking for SYNC or timeout
// NRZI_DATA  | SYNC found, payload bits streamed downstream
// NRZI_ABORT | packet abandoned; wait for rx_active to drop
module nrzi_decode_fsm
    import usb_pkg::*;
(
    input  logic            clock,
    input  logic            reset_n,
    input  logic            rx_active,
    input  logic            sync_match,
    input  logic            hunt_timeout,
`ifdef NRZI_STUFF_ERR_EN
    input  logic            stuff_hit,
`endif
    output nrzi_dec_state_t state,
    output logic            sync_ok,
    output logic            sync_err,
    output logic            rx_done,
    output logic            stuff_err
);

    nrzi_dec_state_t state_d;
    logic            sync_ok_d;
    logic            sync_err_d;
    logic            rx_done_d;
    logic            stuff_err_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= NRZI_IDLE;
            sync_ok  <= 1'b0;
            sync_err <= 1'b0;
            rx_done  <= 1'b0;
        end else begin
            state    <= state_d;
            sync_ok  <= sync_ok_d;
            sync_err <= sync_err_d;
            rx_done  <= rx_done_d;
        end
    end

    always_comb begin
        state_d     = state;
        sync_ok_d   = 1'b0;
        sync_err_d  = 1'b0;
        rx_done_d   = 1'b0;
        stuff_err_d = 1'b0;
        case (state)
            NRZI_IDLE: begin
                if (rx_active)
                    state_d = NRZI_HUNT;
            end
            NRZI_HUNT: begin
                if (!rx_active) begin
                    state_d = NRZI_IDLE;
                end else if (sync_match) begin
                    state_d   = NRZI_DATA;
                    sync_ok_d = 1'b1;
                end else if (hunt_timeout) begin
                    state_d    = NRZI_ABORT;
                    sync_err_d = 1'b1;
                end
            end
            NRZI_DATA: begin
                if (!rx_active) begin
                    state_d   = NRZI_IDLE;
                    rx_done_d = 1'b1;
`ifdef NRZI_STUFF_ERR_EN
                end else if (stuff_hit) begin
                    state_d     = NRZI_ABORT;
                    stuff_err_d = 1'b1;
`endif
                end
            end
            NRZI_ABORT: begin
                if (!rx_active)
                    state_d = NRZI_IDLE;
            end
            default: state_d = NRZI_IDLE;
        endcase
    end

`ifdef NRZI_STUFF_ERR_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            stuff_err <= 1'b0;
        else
            stuff_err <= stuff_err_d;
    end
`else
    assign stuff_err = 1'b0;
`endif

endmodule

// File: rtl/nrzi_decode.sv
// USB receive NRZI decoder: strips SYNC and streams payload bits with 1-cycle latency.
// Define NRZI_STUFF_ERR_EN to abort packets on a seven-ones bit-stuff violation.
module nrzi_decode
    import usb_pkg::*;
#(
    parameter int unsigned          SYNC_LEN     = 8,
    parameter logic [SYNC_LEN-1:0]  SYNC_PATTERN = SYNC_PATTERN_DEFAULT,
    parameter int unsigned          SYNC_TIMEOUT = 32
)(
    input  logic clock,
    input  logic reset_n,
    input  logic in_bit,
    input  logic rx_active,
    output logic out_bit,
    output logic nrzi_receiving,
    output logic sync_ok,
    output logic rx_done,
    output logic sync_err,
    output logic stuff_err
);

    // hunt_left is a down-counter of bits still allowed before the SYNC timeout.
    localparam logic [7:0] HUNT_LOAD     = 8'(SYNC_TIMEOUT - 1);
    localparam logic [7:0] HUNT_SYNC_MAX = 8'(SYNC_TIMEOUT - SYNC_LEN + 1);

    nrzi_dec_state_t     state;
    logic                prev_line;
    logic                dec;
    logic [SYNC_LEN-2:0] shift_q;
    logic [SYNC_LEN-1:0] shift_nxt;
    logic [7:0]          hunt_left;
    logic                sync_match;
    logic                hunt_timeout;
    logic                data_bit;
    logic                stuff_hit;

    assign dec          = nrzi_bit(in_bit, (state == NRZI_IDLE) ? 1'b0 : prev_line);
    assign shift_nxt    = {shift_q, dec};
    assign sync_match   = (shift_nxt == SYNC_PATTERN) && (hunt_left <= HUNT_SYNC_MAX);
    assign hunt_timeout = (hunt_left == 8'd1);
    assign data_bit     = (state == NRZI_DATA) && rx_active;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_line <= 1'b0;
            shift_q   <= '0;
            hunt_left <= 8'd0;
        end else if (!rx_active) begin
            prev_line <= 1'b0;
            shift_q   <= '0;
            hunt_left <= 8'd0;
        end else begin
            prev_line <= in_bit;
            case (state)
                NRZI_IDLE: begin
                    shift_q   <= shift_nxt[SYNC_LEN-2:0];
                    hunt_left <= HUNT_LOAD;
                end
                NRZI_HUNT: begin
                    shift_q   <= shift_nxt[SYNC_LEN-2:0];
                    hunt_left <= hunt_left - 8'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef NRZI_STUFF_ERR_EN
    logic [2:0] ones_run;

    assign stuff_hit = data_bit && dec && (ones_run == 3'(MAX_ONES_RUN));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            ones_run <= 3'd0;
        else if (data_bit && !stuff_hit)
            ones_run <= dec ? ones_run + 3'd1 : 3'd0;
        else
            ones_run <= 3'd0;
    end
`else
    assign stuff_hit = 1'b0;
`endif

    // out_bit only updates on payload bits; it holds stale data otherwise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_bit        <= 1'b0;
            nrzi_receiving <= 1'b0;
        end else begin
            nrzi_receiving <= data_bit && !stuff_hit;
            if (data_bit)
                out_bit <= dec;
        end
    end

    nrzi_decode_fsm u_fsm (
        .clock        (clock),
        .reset_n      (reset_n),
        .rx_active    (rx_active),
        .sync_match   (sync_match),
        .hunt_timeout (hunt_timeout),
`ifdef NRZI_STUFF_ERR_EN
        .stuff_hit    (stuff_hit),
`endif
        .state        (state),
        .sync_ok      (sync_ok),
        .sync_err     (sync_err),
        .rx_done      (rx_done),
        .stuff_err    (stuff_err)
    );

endmodule

// File: tb/tb_nrzi_decode.sv
// Directed testbench for nrzi_decode; expectations are hand-computed line/decoded bits.
// Honors NRZI_STUFF_ERR_EN for the bit-stuff expectations.
module tb_nrzi_decode;

`ifdef NRZI_STUFF_ERR_EN
    localparam bit STUFF_EN = 1'b1;
`else
    localparam bit STUFF_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset_n;
    logic in_bit;
    logic rx_active;
    logic out_bit;
    logic nrzi_receiving;
    logic sync_ok;
    logic rx_done;
    logic sync_err;
    logic stuff_err;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    nrzi_decode dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .in_bit         (in_bit),
        .rx_active      (rx_active),
        .out_bit        (out_bit),
        .nrzi_receiving (nrzi_receiving),
        .sync_ok        (sync_ok),
        .rx_done        (rx_done),
        .sync_err       (sync_err),
        .stuff_err      (stuff_err)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one line bit, then sample 1 time unit after the consuming edge.
    task automatic cyc(input logic b, input logic a);
        in_bit    = b;
        rx_active = a;
        @(posedge clock);
        #1;
    endtask

    // SYNC as sent from encoder level 0: line J K J K J K J J.
    task automatic send_sync(input string tag);
        logic [7:0] line = 8'b1010_1011;
        for (int i = 0; i < 8; i++) begin
            cyc(line[7-i], 1'b1);
            chk({tag, " sync_ok"}, sync_ok, (i == 7));
            chk({tag, " recv_in_sync"}, nrzi_receiving, 1'b0);
        end
    endtask

    // line[i] / expd[i] are the i-th transmitted / decoded payload bits.
    task automatic send_data(input string tag, input logic [15:0] line,
                             input logic [15:0] expd, input int n);
        for (int i = 0; i < n; i++) begin
            cyc(line[i], 1'b1);
            chk({tag, " recv"}, nrzi_receiving, 1'b1);
            chk({tag, " out_bit"}, out_bit, expd[i]);
            chk({tag, " sync_ok_low"}, sync_ok, 1'b0);
        end
    endtask

    task automatic end_pkt(input string tag, input logic exp_done);
        cyc(1'b0, 1'b0);
        chk({tag, " recv_end"}, nrzi_receiving, 1'b0);
        chk({tag, " rx_done"}, rx_done, exp_done);
        cyc(1'b0, 1'b0);
        chk({tag, " rx_done_pulse"}, rx_done, 1'b0);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_bit    = 1'b0;
        rx_active = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst out_bit", out_bit, 1'b0);
        chk("rst recv", nrzi_receiving, 1'b0);
        chk("rst sync_ok", sync_ok, 1'b0);
        chk("rst rx_done", rx_done, 1'b0);
        chk("rst sync_err", sync_err, 1'b0);
        chk("rst stuff_err", stuff_err, 1'b0);
        reset_n = 1'b1;
        cyc(1'b0, 1'b0);

        // SYNC then line 0,1,1,0 -> decoded 0,0,1,0
        send_sync("t1");
        send_data("t1", 16'b0110, 16'b0100, 4);
        end_pkt("t1", 1'b1);

        // Encoded byte A5 (LSB first) after SYNC
        send_sync("t2");
        send_data("t2", 16'h00C9, 16'h00A5, 8);
        end_pkt("t2", 1'b1);

        // Constant J: no SYNC, timeout on the 32nd bit
        for (int i = 1; i <= 40; i++) begin
            cyc(1'b1, 1'b1);
            chk("t3 sync_err", sync_err, (i == 32));
            chk("t3 recv", nrzi_receiving, 1'b0);
            chk("t3 sync_ok", sync_ok, 1'b0);
        end
        end_pkt("t3", 1'b0);

        // rx_active drops during HUNT: silent return to IDLE
        repeat (3) cyc(1'b1, 1'b1);
        end_pkt("t3b", 1'b0);

        // Back-to-back packets with a single-cycle gap
        send_sync("t4a");
        send_data("t4a", 16'b10, 16'b00, 2);
        cyc(1'b0, 1'b0);
        chk("t4 gap rx_done", rx_done, 1'b1);
        chk("t4 gap recv", nrzi_receiving, 1'b0);
        send_sync("t4b");
        send_data("t4b", 16'b011, 16'b011, 3);
        end_pkt("t4b", 1'b1);

        // Reset mid-DATA, then a clean packet
        send_sync("t5");
        send_data("t5", 16'b00, 16'b10, 2);
        reset_n   = 1'b0;
        rx_active = 1'b0;
        #1;
        chk("t5 rst out_bit", out_bit, 1'b0);
        chk("t5 rst recv", nrzi_receiving, 1'b0);
        chk("t5 rst sync_ok", sync_ok, 1'b0);
        @(posedge clock);
        #1;
        chk("t5 rst rx_done", rx_done, 1'b0);
        reset_n = 1'b1;
        cyc(1'b0, 1'b0);
        chk("t5 post rx_done", rx_done, 1'b0);
        send_sync("t5n");
        send_data("t5n", 16'h00C9, 16'h00A5, 8);
        end_pkt("t5n", 1'b1);

        // Seven decoded ones after SYNC
        send_sync("t6");
        for (int i = 1; i <= 7; i++) begin
            cyc(1'b1, 1'b1);
            chk("t6 stuff_err", stuff_err, STUFF_EN && (i == 7));
            chk("t6 recv", nrzi_receiving, !(STUFF_EN && (i == 7)));
            chk("t6 out_bit", out_bit, 1'b1);
        end
        cyc(1'b1, 1'b1);
        chk("t6 8th recv", nrzi_receiving, !STUFF_EN);
        chk("t6 8th stuff_err", stuff_err, 1'b0);
        end_pkt("t6", !STUFF_EN);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
